// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter.
// Sends start / DATA_WIDTH data bits (LSB first) / optional parity / 1 or 2 stop bits.
// Each serial bit is held for OVERSAMPLE bclk cycles. Framing options are latched
// when a frame is accepted, so later changes on the inputs cannot corrupt it.
module uart_tx_cfg #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TICK_W     = $clog2(OVERSAMPLE),
  parameter int BIT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  bclk,
  input  logic                  reset,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_din,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tk
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_WIDTH - 1);

  state_t                state;
  logic [TICK_W-1:0]     tick;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_bit;
  logic                  parity_en;
  logic                  stop2_q;
  logic                  stop_cnt;
  logic                  bit_end;

  assign bit_end = (tick == TICK_MAX);

  // Frame sequencer: tick counting, bit sequencing and all registered outputs
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      parity_en  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done_tk <= 1'b0;
    end else begin
      tx_done_tk <= 1'b0;

      if (state != IDLE) begin
        if (bit_end) begin
          tick <= '0;
        end else begin
          tick <= tick + TICK_W'(1);
        end
      end

      case (state)
        IDLE: begin
          tick    <= '0;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shift_reg  <= tx_din;
            parity_bit <= (parity_mode == 2'b10) ? ~(^tx_din) : (^tx_din);
            parity_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            stop2_q    <= stop2;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tx    <= shift_reg[0];
            state <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == BIT_MAX) begin
              bit_cnt <= '0;
              if (parity_en) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shift_reg[1];
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              stop_cnt   <= 1'b0;
              tx_busy    <= 1'b0;
              tx_done_tk <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed self-checking bench for uart_tx_cfg (OVERSAMPLE=16, DATA_WIDTH=8).
// Outputs are sampled on the falling edge; cycle 0 is the cycle right after the accept edge.
module tb_uart_tx_cfg;

  localparam int OS = 16;

  logic       bclk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_din;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tk;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_tx_cfg #(
    .OVERSAMPLE(OS),
    .DATA_WIDTH(8)
  ) dut (
    .bclk        (bclk),
    .reset       (reset),
    .tx_start    (tx_start),
    .tx_din      (tx_din),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done_tk  (tx_done_tk)
  );

  // Free-running oversampled baud clock
  always #5 bclk = ~bclk;

  // Hard time limit so the bench always terminates
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input int cyc, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s (cycle %0d): observed %b, expected %b", tag, cyc, observed, expected);
    end
  endtask

  // Expected line level in a given cycle of a frame, from the hand-chosen data and parity bit
  function automatic logic exp_tx(input logic [7:0] data, input logic has_par, input logic par_bit, input int c);
    int i;
    i = c / OS;
    if (i == 0) return 1'b0;
    else if (i <= 8) return data[i-1];
    else if (i == 9 && has_par) return par_bit;
    else return 1'b1;
  endfunction

  task automatic apply_stimulus(input logic [7:0] data, input logic [1:0] mode, input logic s2);
    @(negedge bclk);
    tx_din      = data;
    parity_mode = mode;
    stop2       = s2;
    tx_start    = 1'b1;
    @(posedge bclk);
  endtask

  // Walk a whole frame cycle by cycle; returns on the falling edge of the done cycle
  task automatic check_frame(input logic [7:0] data, input logic has_par, input logic par_bit,
                             input int exp_len, input int pulse_at, input logic hold, input string tag);
    for (int c = 0; c <= exp_len; c++) begin
      @(negedge bclk);
      if (!hold && c == 0) begin
        tx_start    = 1'b0;
        tx_din      = ~tx_din;
        parity_mode = ~parity_mode;
        stop2       = ~stop2;
      end
      if (c == pulse_at) begin
        tx_start = 1'b1;
        tx_din   = 8'h0F;
      end
      if (pulse_at >= 0 && c == pulse_at + 1) tx_start = 1'b0;
      if (c < exp_len) begin
        check_output({tag, " tx"}, c, tx, exp_tx(data, has_par, par_bit, c));
        check_output({tag, " busy"}, c, tx_busy, 1'b1);
        check_output({tag, " done"}, c, tx_done_tk, 1'b0);
      end else begin
        check_output({tag, " done_pulse"}, c, tx_done_tk, 1'b1);
        check_output({tag, " busy_at_done"}, c, tx_busy, 1'b0);
        check_output({tag, " tx_at_done"}, c, tx, 1'b1);
      end
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(negedge bclk);
      check_output({tag, " tx"}, c, tx, 1'b1);
      check_output({tag, " busy"}, c, tx_busy, 1'b0);
      check_output({tag, " done"}, c, tx_done_tk, 1'b0);
    end
  endtask

  // Directed test sequence
  initial begin
    reset       = 1'b1;
    tx_start    = 1'b0;
    tx_din      = 8'h00;
    parity_mode = 2'b00;
    stop2       = 1'b0;

    repeat (3) @(negedge bclk);
    check_output("reset tx", 0, tx, 1'b1);
    check_output("reset busy", 0, tx_busy, 1'b0);
    check_output("reset done", 0, tx_done_tk, 1'b0);
    reset = 1'b0;
    idle_check(4, "idle");

    // 0x55 8N1: 0,1,0,1,0,1,0,1,0,1 -> 160 cycles
    apply_stimulus(8'h55, 2'b00, 1'b0);
    check_frame(8'h55, 1'b0, 1'b0, 160, -1, 1'b0, "f55_8N1");

    // 0xA3 has four ones: even parity bit 0, odd parity bit 1 -> 176 cycles
    apply_stimulus(8'hA3, 2'b01, 1'b0);
    check_frame(8'hA3, 1'b1, 1'b0, 176, -1, 1'b0, "fA3_even");
    apply_stimulus(8'hA3, 2'b10, 1'b0);
    check_frame(8'hA3, 1'b1, 1'b1, 176, -1, 1'b0, "fA3_odd");

    // Two stop bits: 192 cycles with parity, 176 with reserved mode 11 (no parity)
    apply_stimulus(8'hA3, 2'b01, 1'b1);
    check_frame(8'hA3, 1'b1, 1'b0, 192, -1, 1'b0, "fA3_even_2stop");
    apply_stimulus(8'hA3, 2'b11, 1'b1);
    check_frame(8'hA3, 1'b0, 1'b0, 176, -1, 1'b0, "fA3_mode11_2stop");

    // Back-to-back: tx_start held, data switched in the done cycle
    apply_stimulus(8'h00, 2'b00, 1'b0);
    check_frame(8'h00, 1'b0, 1'b0, 160, -1, 1'b1, "b2b_first");
    tx_din = 8'hFF;
    @(posedge bclk);
    check_frame(8'hFF, 1'b0, 1'b0, 160, -1, 1'b1, "b2b_second");
    tx_start = 1'b0;
    idle_check(20, "b2b_idle");

    // tx_start pulsed at cycle 40 with other data must be ignored
    apply_stimulus(8'h5A, 2'b00, 1'b0);
    check_frame(8'h5A, 1'b0, 1'b0, 160, 40, 1'b0, "ignore");
    idle_check(20, "ignore_idle");

    // Reset at cycle 70 (data bit 3 of 0xC3, which is 0) aborts the frame
    apply_stimulus(8'hC3, 2'b00, 1'b0);
    for (int c = 0; c <= 70; c++) begin
      @(negedge bclk);
      if (c == 0) tx_start = 1'b0;
    end
    check_output("pre_reset tx", 70, tx, 1'b0);
    reset = 1'b1;
    #1;
    check_output("abort tx", 70, tx, 1'b1);
    check_output("abort busy", 70, tx_busy, 1'b0);
    check_output("abort done", 70, tx_done_tk, 1'b0);
    repeat (3) @(negedge bclk);
    reset = 1'b0;
    idle_check(3, "post_reset_idle");

    apply_stimulus(8'h3C, 2'b00, 1'b0);
    check_frame(8'h3C, 1'b0, 1'b0, 160, -1, 1'b0, "f3C_after_reset");
    idle_check(5, "final_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter; successor to the fixed 8N1 transmitter. Serialises a DATA_WIDTH-bit word as start / data (LSB first) / optional parity / 1 or 2 stop bits. Each bit is held for OVERSAMPLE bclk cycles; bclk is the oversampled baud tick clock. It sits between the TX holding logic or FIFO and the pad, with a busy/done handshake toward the producer.

Parameters:
OVERSAMPLE, 16, bclk cycles per serial bit; legal range 2..256.
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
TICK_W, $clog2(OVERSAMPLE), width of the tick counter. Derived; do not override.
BIT_W, $clog2(DATA_WIDTH), width of the data-bit counter. Derived; do not override.

Ports:
bclk  input  1  oversampled baud clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
tx_start  input  1  request to send tx_din; sampled only in IDLE
tx_din  input  DATA_WIDTH  word to transmit; captured on accept
parity_mode  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none); captured on accept
stop2  input  1  0 = one stop bit, 1 = two stop bits; captured on accept
tx  output  1  serial line, registered; idle-high
tx_busy  output  1  high while a frame is in progress
tx_done_tk  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (asynchronous): state=IDLE, tx=1, tx_busy=0, tx_done_tk=0, all counters and the shift register cleared. Reset asserted mid-frame aborts the frame immediately; tx returns to 1 with no partial stop bit.
- All outputs are registered. tx never glitches.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_busy=0.
  - On a rising edge with tx_start=1: capture tx_din into the shift register, and capture parity_mode and stop2.
  - Compute the parity bit from the captured data: even = XOR of the data bits; odd = inverted XOR.
  - Next state is START, with tx=0 and tx_busy=1 in the following cycle.
  - Accept latency is 1 cycle.
- START: tx=0 for OVERSAMPLE cycles, then go to DATA.
- DATA: tx = shift_reg[0]. After OVERSAMPLE cycles, shift right and increment the bit counter.
  - After bit DATA_WIDTH-1: go to PARITY if the captured mode is 01 or 10, else go to STOP.
- PARITY: tx = captured parity bit for OVERSAMPLE cycles, then go to STOP.
- STOP: tx=1 for OVERSAMPLE cycles (1 stop bit) or 2*OVERSAMPLE cycles (2 stop bits).
  - On the final stop cycle edge: state goes to IDLE, tx_done_tk=1 for exactly one cycle, and tx_busy=0 in that same cycle.
- Tick counter:
  - Counts 0..OVERSAMPLE-1 and wraps to 0 at each bit boundary.
  - Held at 0 in IDLE.
  - The 2-stop-bit case counts two full wraps, using a 1-bit stop counter.
- Frame length from accept edge to done edge = (1 + DATA_WIDTH + P + S) * OVERSAMPLE cycles, where P is 0 or 1 and S is 1 or 2.
- tx_start while tx_busy=1 is ignored. No queuing.
- tx_din, parity_mode and stop2 changes mid-frame have no effect on the current frame.
- Back-to-back frames: tx_start=1 in the tx_done_tk cycle (state is IDLE) is accepted. The next start bit begins the following cycle, with zero idle gap beyond the stop bits.
- Reserved parity_mode=11 behaves exactly as 00.

Test Plan:
- Reset, then send 0x55 with mode 00, stop2=0 (8N1, OVERSAMPLE=16) -> tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles; tx_done_tk pulses 160 cycles after the accept edge; tx_busy high for 160 cycles.
- Send 0xA3 with mode 01 (even parity) -> parity bit 0 (four ones). Send 0xA3 with mode 10 (odd parity) -> parity bit 1. Frame length 176 cycles in both cases.
- Send 0xA3 with mode 01 and stop2=1 -> tx high for 32 cycles after the parity bit; done pulse at 192 cycles. Repeat with mode 11 -> no parity bit, 176 cycles.
- Hold tx_start=1 continuously with data 0x00 then 0xFF, changing tx_din at each done pulse -> two contiguous frames; the second start bit falls the cycle after tx_done_tk; no extra idle cycles; second frame carries 0xFF.
- Pulse tx_start at cycle 40 of a frame with different tx_din -> ignored; the current frame completes unchanged and no second frame is sent.
- Assert reset at cycle 70 of a frame (during a data bit) -> tx=1, tx_busy=0, tx_done_tk=0 immediately. After reset release a new 0x3C 8N1 frame transmits correctly.
